serial_subtractor: RTL

Bit-serial N-bit subtractor that computes D = A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's 1-bit full adder, and is the sequential arithmetic primitive for the datapath labs. Operands are captured on a start handshake. The result and flags are presented with a one-cycle done pulse and held until the next operation.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow. Results are held until
// the next completed operation.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_amsb;
  logic             r_bmsb;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_v;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  // Full-subtractor cell on the current LSBs and the registered borrow
  assign w_a      = r_a_sh[0];
  assign w_b      = r_b_sh[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

  assign w_load  = (r_state == S_IDLE) && start;
  assign w_shift = (r_state == S_SHIFT);
  assign w_last  = w_shift && (r_cnt == CW'(WIDTH - 1));

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, shifting, borrow and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
    end else if (w_load) begin
      r_a_sh <= A;
      r_b_sh <= B;
      r_br   <= Bin;
      r_cnt  <= '0;
      r_amsb <= A[WIDTH-1];
      r_bmsb <= B[WIDTH-1];
    end else if (w_shift) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_br   <= w_br_nxt;
      // Counter saturates at WIDTH-1 rather than wrapping
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Registered status and result outputs; results only move on the last shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_v    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      if (w_last) begin
        r_d    <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_br_nxt;
        r_v    <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;
  assign V    = r_v;

endmodule
